// File: rtl/can_pkg.sv
// Shared CAN frame definitions for the receiver and the transmitter.
package can_pkg;

    // Field widths
    localparam int unsigned ID_W   = 12;
    localparam int unsigned CTRL_W = 7;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CRC_W  = 15;

    // Whole frame, and the bits 1..98 that are assembled before the trailer
    localparam int unsigned FRAME_BITS = 109;
    localparam int unsigned ASM_W      = 98;

    // Bit index of each field within the frame
    localparam logic [6:0] BIT_SOF     = 7'd0;
    localparam logic [6:0] BIT_ID_LO   = 7'd1;
    localparam logic [6:0] BIT_CTRL_LO = 7'd13;
    localparam logic [6:0] BIT_DATA_LO = 7'd20;
    localparam logic [6:0] BIT_CRC_LO  = 7'd84;
    localparam logic [6:0] BIT_CRC_HI  = 7'd98;
    localparam logic [6:0] BIT_DELIM   = 7'd99;
    localparam logic [6:0] BIT_ACK_LO  = 7'd100;
    localparam logic [6:0] BIT_EOF_LO  = 7'd102;
    localparam logic [6:0] BIT_LAST    = 7'd108;

    localparam logic [CRC_W-1:0] CRC_VALUE = 15'h2001;

    // Abort causes
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CRC  = 2'b01;
    localparam logic [1:0] ERR_FORM = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF_CHK,
        ST_RECV,
        ST_TRAIL,
        ST_DONE,
        ST_ERR,
        ST_WAIT_IDLE
    } rx_state_t;

    // Trailer bits that must be recessive: the CRC delimiter and the EOF field
    function automatic logic trail_bit_must_be_one(input logic [6:0] k);
        return (k == BIT_DELIM) || (k >= BIT_EOF_LO);
    endfunction

endpackage

// File: rtl/can_bit_sampler.sv
// Bit-time counter: one-cycle strobe H cycles after restart, then every CLKS_PER_BIT cycles.
module can_bit_sampler
    import can_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic strobe
);

    localparam int unsigned H        = (CLKS_PER_BIT - 1) / 2;
    localparam logic [7:0]  LAST_CNT = 8'(CLKS_PER_BIT - 1);
    // Loaded on the restart cycle so that LAST_CNT is reached at offset H;
    // when H is 0 the first strobe lands one full bit time later.
    localparam logic [7:0]  LOAD_CNT = 8'((CLKS_PER_BIT - H) % CLKS_PER_BIT);

    logic [7:0] cnt;

    assign strobe = (cnt == LAST_CNT);

    // Free-running modulo-CLKS_PER_BIT counter, realigned on restart
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= LOAD_CNT;
        end else if (cnt == LAST_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/can_rx.sv
// CAN frame receiver: SOF detect, fixed 109-bit deserialiser, CRC/form checks.
module can_rx
    import can_pkg::*;
#(
    parameter int unsigned       CLKS_PER_BIT = 1,
    parameter logic [CRC_W-1:0]  CRC_CHECK    = CRC_VALUE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Can_in,
    output logic [ID_W-1:0]   rx_id,
    output logic [CTRL_W-1:0] rx_control,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_error,
    output logic [1:0]        rx_err_code,
    output logic              busy
);

    localparam int unsigned H           = (CLKS_PER_BIT - 1) / 2;
    // With H = 0 the IDLE-cycle sample is already the SOF sample
    localparam bit          SOF_IN_IDLE = (H == 0);

    rx_state_t        state;
    logic [6:0]       bit_idx;
    logic [ASM_W-1:0] shreg;
    logic [2:0]       ones_cnt;
    logic             restart;
    logic             strobe;

    assign restart = ((state == ST_IDLE) && !Can_in) || (state == ST_ERR);

    can_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clock  (clock),
        .reset  (reset),
        .restart(restart),
        .strobe (strobe)
    );

    // Frame FSM with registered outputs; bits enter shreg at the MSB so that
    // after bit 98 frame bit k sits at shreg[k-1].
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_idx     <= '0;
            shreg       <= '0;
            ones_cnt    <= '0;
            rx_id       <= '0;
            rx_control  <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_error    <= 1'b0;
            rx_err_code <= ERR_NONE;
            busy        <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!Can_in) begin
                        busy    <= 1'b1;
                        bit_idx <= BIT_ID_LO;
                        state   <= SOF_IN_IDLE ? ST_RECV : ST_SOF_CHK;
                    end
                end
                ST_SOF_CHK: begin
                    if (strobe) begin
                        if (Can_in) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    if (strobe) begin
                        shreg   <= {Can_in, shreg[ASM_W-1:1]};
                        bit_idx <= bit_idx + 7'd1;
                        if (bit_idx == BIT_CRC_HI) begin
                            if ({Can_in, shreg[ASM_W-1:ASM_W-CRC_W+1]} != CRC_CHECK) begin
                                state       <= ST_ERR;
                                rx_error    <= 1'b1;
                                rx_err_code <= ERR_CRC;
                            end else begin
                                state <= ST_TRAIL;
                            end
                        end
                    end
                end
                ST_TRAIL: begin
                    if (strobe) begin
                        bit_idx <= bit_idx + 7'd1;
                        if (!Can_in && trail_bit_must_be_one(bit_idx)) begin
                            state       <= ST_ERR;
                            rx_error    <= 1'b1;
                            rx_err_code <= ERR_FORM;
                        end else if (bit_idx == BIT_LAST) begin
                            state      <= ST_DONE;
                            rx_valid   <= 1'b1;
                            rx_id      <= shreg[ID_W-1:0];
                            rx_control <= shreg[ID_W+CTRL_W-1:ID_W];
                            rx_data    <= shreg[ID_W+CTRL_W+DATA_W-1:ID_W+CTRL_W];
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_ERR: begin
                    state    <= ST_WAIT_IDLE;
                    ones_cnt <= '0;
                end
                ST_WAIT_IDLE: begin
                    if (strobe) begin
                        if (!Can_in) begin
                            ones_cnt <= '0;
                        end else if (ones_cnt == 3'd6) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            ones_cnt <= '0;
                        end else begin
                            ones_cnt <= ones_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/can_rx.md
# can_rx

CAN frame receiver: the counterpart of the team's `can_tx` transmitter on the single-wire CAN line.
- Samples `Can_in`, detects start-of-frame and deserialises the fixed 109-bit frame (no bit stuffing, no arbitration).
- Checks CRC, delimiter and end-of-frame fields.
- Presents the ID, control and data fields to the CAN-to-UART path with a one-cycle valid or error pulse.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1: clock cycles per CAN bit. Legal range is 1–255.
- `CRC_CHECK`, default 15'h2001: constant CRC value the transmitter emits. A mismatch is a CRC error.

Ports:
- `clock`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Can_in`  in  1  CAN line. 1 = recessive, 0 = dominant. Already synchronous to `clock`.
- `rx_id`  out  12  ID field of the last good frame.
- `rx_control`  out  7  control field (DLC/RTR/IDE) of the last good frame.
- `rx_data`  out  64  data field of the last good frame.
- `rx_valid`  out  1  one-cycle pulse: the `rx_*` fields were updated this cycle.
- `rx_error`  out  1  one-cycle pulse: the current frame was aborted.
- `rx_err_code`  out  2  cause of the abort: 01 = CRC, 10 = form (delimiter/EOF). Holds its value until the next `rx_error`.
- `busy`  out  1  high in every state except IDLE.

## Operation
Frame layout, bit index k, LSB of each field first:
- k=0: SOF, must be 0.
- k=1–12: ID.
- k=13–19: control.
- k=20–83: data.
- k=84–98: CRC.
- k=99: CRC delimiter, must be 1.
- k=100–101: ACK, values ignored.
- k=102–108: EOF, all must be 1.

States:
- **IDLE**
  - `Can_in`=0 at cycle t0 → SOF_CHK.
- **SOF_CHK**
  - Wait H=(CLKS_PER_BIT-1)/2 cycles (integer division), then sample.
  - Sample 0 → RECV with k=1. Sample 1 → IDLE silently; this is a glitch and is not an error.
  - When CLKS_PER_BIT=1, the sample at t0 itself is the SOF sample.
- **RECV**
  - Sample each bit at t0+H+k·CLKS_PER_BIT and shift it into an internal 98-bit assembly register.
  - At k=98, compare the CRC field with `CRC_CHECK`. On mismatch → ERR with code 01.
  - Otherwise continue to k=99 → TRAIL.
- **TRAIL**
  - k=99–108.
  - Any 0 at k=99 or at k=102–108 → ERR with code 10.
  - After k=108 sampled as 1 → DONE.
- **DONE**
  - One cycle: copy the assembled fields to `rx_id`, `rx_control` and `rx_data`; pulse `rx_valid`.
  - → IDLE.
- **ERR**
  - One cycle: pulse `rx_error` and latch `rx_err_code`; the `rx_*` data outputs are unchanged.
  - → WAIT_IDLE.
- **WAIT_IDLE**
  - Count consecutive recessive bit samples, one per bit time, restarting from the current cycle.
  - A 0 clears the count.
  - 7 consecutive 1s → IDLE.

Boundary rules:
- `reset` overrides everything. State returns to IDLE. Outputs go to: `rx_id`/`rx_control`/`rx_data`=0, `rx_valid`=0, `rx_error`=0, `rx_err_code`=00, `busy`=0.
- Reset mid-frame discards the partial frame with no pulse.
- Back-to-back frames: a new SOF is accepted the first IDLE cycle after DONE.
- `Can_in` held at 0 after an error keeps the block in WAIT_IDLE indefinitely.
- `rx_valid` and `rx_error` are never high in the same cycle.

## Timing
- Reset is synchronous; the reset values above take effect on the first rising edge of `clock` with `reset`=1.
- Sample position of bit k: t0+H+k·CLKS_PER_BIT.
- `rx_valid` is high exactly one cycle, at cycle t0+H+108·CLKS_PER_BIT+1. Outputs become valid in the same cycle as the pulse.
- `rx_error` is high one cycle, in the cycle after the offending sample.
- `busy` rises the cycle after t0 and falls the cycle after DONE. After an error, it falls when WAIT_IDLE exits.
- With CLKS_PER_BIT=1, the receiver accepts `can_tx` output directly, one bit per clock, with no gaps.

## Structure
- Shared package `can_pkg` holds:
  - field widths (12/7/64/15);
  - bit-index constants (SOF=0, ID_LO=1, CTRL_LO=13, DATA_LO=20, CRC_LO=84, DELIM=99, ACK_LO=100, EOF_LO=102, LAST=108);
  - `FRAME_BITS`=109;
  - default `CRC_VALUE`=15'h2001;
  - error-code constants;
  - state encoding.
- `can_tx` is to import the same package.
- One sub-module, `can_bit_sampler`: a bit-time counter that produces a one-cycle sample strobe at offset H, then every CLKS_PER_BIT cycles. It is restarted by the FSM at t0 and when WAIT_IDLE is entered.

## Test plan
- CLKS_PER_BIT=1, loopback from `can_tx` with ID=12'hABC, control=7'h20, data=64'h0123_4567_89AB_CDEF → `rx_valid` pulse one cycle after bit 108, fields match exactly, `busy` drops.
- CLKS_PER_BIT=4, same frame driven by a bench serialiser → `rx_valid` at t0+1+108·4+1; CRC 15'h2001 accepted.
- CRC field 15'h2002 → `rx_error` the cycle after bit 98, `rx_err_code`=01, `rx_*` fields keep the previous frame. Then 7 recessive bits → back to IDLE.
- EOF bit 104 forced to 0 → `rx_error` with code 10. Line held low for 20 bits keeps `busy`=1; release → IDLE after 7 recessive bits.
- CLKS_PER_BIT=8, 2-cycle dominant glitch → no pulse, back to IDLE. Also: two back-to-back frames with a 1-cycle gap → two `rx_valid` pulses.
- `reset` asserted at bit 50 → all outputs 0 the next cycle, no pulse; the next complete frame is received correctly.
